// File: rtl/reg16_bank_arbiter.sv
// reg16_bank_arbiter
// Round-robin arbiter and sequencer for a bank of NREGS 16-bit byte-enabled
// registers shared by two Avalon-MM slave ports (A: fabric, B: local engine).
// Each granted access takes one SERVE cycle (waitrequest low) and is always
// followed by an IDLE cycle, so a port gets at most one access per two cycles.
module reg16_bank_arbiter #(
    parameter int unsigned NREGS     = 4,
    parameter int unsigned ADDR_W    = 2,
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  a_chipselect,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic [1:0]            a_byteenable,
    input  logic [15:0]           a_writedata,
    output logic [15:0]           a_readdata,
    output logic                  a_waitrequest,
    input  logic                  b_chipselect,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [ADDR_W-1:0]     b_address,
    input  logic [1:0]            b_byteenable,
    input  logic [15:0]           b_writedata,
    output logic [15:0]           b_readdata,
    output logic                  b_waitrequest,
    output logic [16*NREGS-1:0]   Q_export
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_b;      // 1 when port B holds the most recent grant
    logic [15:0]        r_regs [NREGS];
    logic [15:0]        r_a_rdata;
    logic [15:0]        r_b_rdata;

    logic               w_req_a;
    logic               w_req_b;
    logic [15:0]        w_a_rd;
    logic [15:0]        w_b_rd;
    logic               w_wr_en;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [1:0]         w_wr_be;
    logic [15:0]        w_wr_data;

    assign w_req_a = a_chipselect & (a_read | a_write);
    assign w_req_b = b_chipselect & (b_read | b_write);

    // Next-state arbitration and waitrequest generation
    always_comb begin
        w_state_nxt   = IDLE;
        a_waitrequest = 1'b1;
        b_waitrequest = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_req_a && (!w_req_b || r_last_b)) begin
                    w_state_nxt = SERVE_A;
                end else if (w_req_b) begin
                    w_state_nxt = SERVE_B;
                end
            end
            SERVE_A: a_waitrequest = 1'b0;
            SERVE_B: b_waitrequest = 1'b0;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Register read muxes; an address with no matching register reads as zero
    always_comb begin
        w_a_rd = '0;
        w_b_rd = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (a_address == ADDR_W'(i)) w_a_rd = r_regs[i];
            if (b_address == ADDR_W'(i)) w_b_rd = r_regs[i];
        end
    end

    // Select the write source for the port currently being served
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_be   = '0;
        w_wr_data = '0;
        if (r_state == SERVE_A) begin
            w_wr_en   = w_req_a & a_write;
            w_wr_addr = a_address;
            w_wr_be   = a_byteenable;
            w_wr_data = a_writedata;
        end else if (r_state == SERVE_B) begin
            w_wr_en   = w_req_b & b_write;
            w_wr_addr = b_address;
            w_wr_be   = b_byteenable;
            w_wr_data = b_writedata;
        end
    end

    // Byte-merged register write at the edge that ends a SERVE cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= RESET_VAL;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (w_wr_en && (w_wr_addr == ADDR_W'(i))) begin
                    if (w_wr_be[0]) r_regs[i][7:0]  <= w_wr_data[7:0];
                    if (w_wr_be[1]) r_regs[i][15:8] <= w_wr_data[15:8];
                end
            end
        end
    end

    // State register, grant history and read-data hold registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_last_b  <= 1'b1;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == SERVE_A) begin
                r_a_rdata <= w_a_rd;
                if (w_req_a) r_last_b <= 1'b0;
            end
            if (r_state == SERVE_B) begin
                r_b_rdata <= w_b_rd;
                if (w_req_b) r_last_b <= 1'b1;
            end
        end
    end

    // Read data is live during the port's SERVE cycle, held otherwise
    always_comb begin
        a_readdata = (r_state == SERVE_A) ? w_a_rd : r_a_rdata;
        b_readdata = (r_state == SERVE_B) ? w_b_rd : r_b_rdata;
    end

    // Flat export of the register bank
    always_comb begin
        Q_export = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            Q_export[16*i +: 16] = r_regs[i];
        end
    end

endmodule
